// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg -- shared definitions for the multi-cycle MIPS-lite controller.
//
// Contents:
//   * opcode constants (plain integers, zero-extended to OP_W where compared)
//   * FSM state enumeration
//   * field encodings for aluop, alusrc_b, pc_source, regdest, memtoreg
//   * op_class_t: one-hot instruction class produced by opcode_class
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcode constants
  localparam int unsigned RFMT   = 0;
  localparam int unsigned LW     = 35;
  localparam int unsigned SW     = 43;
  localparam int unsigned BEQ    = 4;
  localparam int unsigned J      = 2;
  localparam int unsigned ORI    = 13;
  localparam int unsigned BLTZAL = 34;
  localparam int unsigned JSPAL  = 19;
  localparam int unsigned BALN   = 27;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_ORI_EXEC,
    S_ORI_WB,
    S_BEQ,
    S_JUMP,
    S_LINK_TEST,
    S_LINK_WB,
    S_JSPAL_WR,
    S_JSPAL_J
  } state_e;

  // ALU operation select
  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_OR    = 2'd3
  } aluop_e;

  // ALU B operand select
  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } srcb_e;

  // PC source select
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_RS     = 2'd3
  } pcsrc_e;

  // Destination register select
  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RD = 2'd1,
    RD_RA = 2'd2
  } regdest_e;

  // Register write-data select
  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'd0,
    M2R_MDR    = 2'd1,
    M2R_PC     = 2'd2
  } memtoreg_e;

  // One-hot instruction class; all-zero means the opcode is unknown.
  // bltzal and baln share the link class since they sequence identically.
  typedef struct packed {
    logic lw;
    logic sw;
    logic rfmt;
    logic beq;
    logic jump;
    logic ori;
    logic link;
    logic jspal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if -- controller <-> datapath/memory signal bundle.
//
// Parameter: OP_W  opcode width
// Status (datapath -> controller): opcode, mem_ready, zero, neg
// Control (controller -> datapath): pc_write, pc_write_cond, iord, mem_read,
//   mem_write, ir_write, regdest, memtoreg, regwrite, alusrc_a, alusrc_b,
//   aluop, pc_source, illegal_op, mem_err, instr_done
// Modports: master = controller side, slave = datapath side.
// ----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opcode;
  logic            mem_ready;
  logic            zero;
  logic            neg;

  logic            pc_write;
  logic            pc_write_cond;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic [1:0]      regdest;
  logic [1:0]      memtoreg;
  logic            regwrite;
  logic            alusrc_a;
  logic [1:0]      alusrc_b;
  logic [1:0]      aluop;
  logic [1:0]      pc_source;
  logic            illegal_op;
  logic            mem_err;
  logic            instr_done;

  modport master (
    input  opcode, mem_ready, zero, neg,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           regdest, memtoreg, regwrite, alusrc_a, alusrc_b, aluop,
           pc_source, illegal_op, mem_err, instr_done
  );

  modport slave (
    output opcode, mem_ready, zero, neg,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           regdest, memtoreg, regwrite, alusrc_a, alusrc_b, aluop,
           pc_source, illegal_op, mem_err, instr_done
  );
endinterface

// File: rtl/multicycle_control_opcode_class.sv
// ----------------------------------------------------------------------------
// opcode_class -- combinational opcode classifier for the DECODE transition.
//
// Parameter: OP_W  opcode width
// Ports:
//   opcode   in  OP_W   instruction opcode field
//   cls      out        one-hot op_class_t
//   illegal  out  1     no class matched
// ----------------------------------------------------------------------------
module opcode_class
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  output op_class_t       cls,
  output logic            illegal
);

  localparam int N_OPS = 9;
  localparam int unsigned OP_TABLE [N_OPS] = '{
    RFMT, LW, SW, BEQ, J, ORI, BLTZAL, BALN, JSPAL
  };

  logic [N_OPS-1:0] hit;

  for (genvar gi = 0; gi < N_OPS; gi++) begin : g_match
    assign hit[gi] = (opcode == OP_W'(OP_TABLE[gi]));
  end

  always_comb begin
    cls       = '0;
    cls.rfmt  = hit[0];
    cls.lw    = hit[1];
    cls.sw    = hit[2];
    cls.beq   = hit[3];
    cls.jump  = hit[4];
    cls.ori   = hit[5];
    cls.link  = hit[6] | hit[7];
    cls.jspal = hit[8];
    illegal   = ~|hit;
  end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control -- Moore-style sequencer for the multi-cycle MIPS-lite
// datapath (R-format, lw, sw, beq, j, ori, bltzal, jspal, baln).
//
// Parameters:
//   OP_W         opcode width
//   MEM_TIMEOUT  waiting cycles on mem_ready before mem_err; 0 disables
//   CNT_W        performance counter width (PERF_CNT_EN builds only)
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high
//   bus    multicycle_control_if.master (status in, datapath controls out)
//   cycle_cnt, instr_cnt  out CNT_W  (PERF_CNT_EN builds only)
// Build option: define PERF_CNT_EN to add the cycle/instruction counters.
// ----------------------------------------------------------------------------
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 15
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
`endif
);

  state_e    state_reg;
  state_e    state_next;
  op_class_t cls;
  logic      illegal;
  logic      mem_state;
  logic      mem_wait;
  logic      timeout;
  logic      mem_err_reg;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] regdest;
  logic [1:0] memtoreg;
  logic       regwrite;
  logic       alusrc_a;
  logic [1:0] alusrc_b;
  logic [1:0] aluop;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       instr_done;

  opcode_class #(
    .OP_W (OP_W)
  ) u_opcode_class (
    .opcode  (bus.opcode),
    .cls     (cls),
    .illegal (illegal)
  );

  // States that hold a memory request open until mem_ready
  assign mem_state = (state_reg == S_FETCH)  || (state_reg == S_MEM_RD) ||
                     (state_reg == S_MEM_WR) || (state_reg == S_JSPAL_WR);
  assign mem_wait  = mem_state && !bus.mem_ready;

  // Wait counter: counts stalled cycles in the current memory state. The
  // timeout fires on the MEM_TIMEOUT-th stalled cycle, so the counter never
  // needs to hold MEM_TIMEOUT itself.
  if (MEM_TIMEOUT > 0) begin : g_timeout
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    logic [WAIT_W-1:0] wait_cnt_reg;

    assign timeout = mem_wait && (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
      if (reset) begin
        wait_cnt_reg <= '0;
      end else if (timeout || (state_next != state_reg)) begin
        wait_cnt_reg <= '0;
      end else if (mem_wait) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sticky memory error
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err_reg <= 1'b0;
    end else if (timeout) begin
      mem_err_reg <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:     if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (cls.lw || cls.sw) state_next = S_MEM_ADDR;
        else if (cls.rfmt)    state_next = S_R_EXEC;
        else if (cls.beq)     state_next = S_BEQ;
        else if (cls.jump)    state_next = S_JUMP;
        else if (cls.ori)     state_next = S_ORI_EXEC;
        else if (cls.link)    state_next = S_LINK_TEST;
        else if (cls.jspal)   state_next = S_JSPAL_WR;
        else                  state_next = S_FETCH;
      end
      S_MEM_ADDR:  state_next = cls.lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (bus.mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WR:    if (bus.mem_ready) state_next = S_FETCH;
      S_R_EXEC:    state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_ORI_EXEC:  state_next = S_ORI_WB;
      S_ORI_WB:    state_next = S_FETCH;
      S_BEQ:       state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
      S_LINK_TEST: state_next = bus.neg ? S_LINK_WB : S_FETCH;
      S_LINK_WB:   state_next = S_FETCH;
      S_JSPAL_WR:  if (bus.mem_ready) state_next = S_JSPAL_J;
      S_JSPAL_J:   state_next = S_FETCH;
      default:     state_next = S_FETCH;
    endcase
    // An abandoned access restarts at FETCH from whichever memory state
    if (timeout) state_next = S_FETCH;
  end

  // Output logic: everything forced low while reset is held
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    regdest       = RD_RT;
    memtoreg      = M2R_ALUOUT;
    regwrite      = 1'b0;
    alusrc_a      = 1'b0;
    alusrc_b      = SRCB_RT;
    aluop         = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          mem_read = 1'b1;
          alusrc_b = SRCB_FOUR;
          ir_write = bus.mem_ready;
          pc_write = bus.mem_ready;
        end
        S_DECODE: begin
          alusrc_b   = SRCB_IMM_SH2;
          illegal_op = illegal;
          instr_done = illegal;
        end
        S_MEM_ADDR: begin
          alusrc_a = 1'b1;
          alusrc_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          regwrite   = 1'b1;
          memtoreg   = M2R_MDR;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = bus.mem_ready;
        end
        S_R_EXEC: begin
          alusrc_a = 1'b1;
          aluop    = ALU_FUNCT;
        end
        S_R_WB: begin
          regwrite   = 1'b1;
          regdest    = RD_RD;
          instr_done = 1'b1;
        end
        S_ORI_EXEC: begin
          alusrc_a = 1'b1;
          alusrc_b = SRCB_IMM;
          aluop    = ALU_OR;
        end
        S_ORI_WB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alusrc_a      = 1'b1;
          aluop         = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          pc_write      = bus.zero;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_LINK_TEST: begin
          alusrc_a   = 1'b1;
          aluop      = ALU_SUB;
          instr_done = !bus.neg;
        end
        S_LINK_WB: begin
          regwrite   = 1'b1;
          regdest    = RD_RA;
          memtoreg   = M2R_PC;
          pc_write   = 1'b1;
          pc_source  = PCSRC_ALUOUT;
          instr_done = 1'b1;
        end
        S_JSPAL_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_JSPAL_J: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_RS;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.iord          = iord;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.regdest       = regdest;
  assign bus.memtoreg      = memtoreg;
  assign bus.regwrite      = regwrite;
  assign bus.alusrc_a      = alusrc_a;
  assign bus.alusrc_b      = alusrc_b;
  assign bus.aluop         = aluop;
  assign bus.pc_source     = pc_source;
  assign bus.illegal_op    = illegal_op;
  assign bus.instr_done    = instr_done;
  assign bus.mem_err       = mem_err_reg && !reset;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic [CNT_W-1:0] instr_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      if (instr_done) instr_cnt_reg <= instr_cnt_reg + 1'b1;
    end
  end

  assign cycle_cnt = reset ? '0 : cycle_cnt_reg;
  assign instr_cnt = reset ? '0 : instr_cnt_reg;
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control -- self-checking bench for multicycle_control.
// A per-instruction script model produces the expected control vector for
// every cycle from the instruction's opcode, flags and memory latencies.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int TO = 15;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] regdest;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_err;
    logic       instr_done;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   err_model = 1'b0;
  int   exp_done = 0;
  int   obs_done = 0;

  multicycle_control_if #(.OP_W(6)) bus ();

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  multicycle_control #(
    .OP_W        (6),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) obs_done <= obs_done + int'(bus.instr_done);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic out_t observe();
    out_t o;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.iord          = bus.iord;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.regdest       = bus.regdest;
    o.memtoreg      = bus.memtoreg;
    o.regwrite      = bus.regwrite;
    o.alusrc_a      = bus.alusrc_a;
    o.alusrc_b      = bus.alusrc_b;
    o.aluop         = bus.aluop;
    o.pc_source     = bus.pc_source;
    o.illegal_op    = bus.illegal_op;
    o.mem_err       = bus.mem_err;
    o.instr_done    = bus.instr_done;
    return o;
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive mem_ready, compare the whole vector mid-cycle.
  task automatic step(input string tag, input out_t exp, input bit rdy);
    out_t e;
    e = exp;
    e.mem_err = err_model;
    bus.mem_ready = rdy;
    @(negedge clk);
    check_val(tag, 32'(observe()), 32'(e));
    if (e.instr_done) exp_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check_val(tag, 32'(observe()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    err_model = 1'b0;
  endtask

  // Memory wait phase: lat stalled cycles then completion; lat >= TO times
  // out after TO stalled cycles; lat < 0 applies reset after two stalls.
  task automatic mem_phase(input string tag, input out_t w, input out_t d,
                           input int lat, output bit ok);
    if (lat < 0) begin
      step(tag, w, 1'b0);
      step(tag, w, 1'b0);
      reset_check({tag, "_reset"});
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < ((lat >= TO) ? TO : lat); i++) step(tag, w, 1'b0);
    if (lat >= TO) begin
      err_model = 1'b1;
      ok = 1'b0;
    end else begin
      step(tag, d, 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic run_instr(input int op, input int lf, input int lm, input bit z, input bit n);
    out_t w;
    out_t d;
    bit   ok;
    bus.opcode = 6'(op);
    bus.zero   = z;
    bus.neg    = n;
    w = '0; w.mem_read = 1; w.alusrc_b = 2'd1;
    d = w;  d.ir_write = 1; d.pc_write = 1;
    mem_phase("fetch", w, d, lf, ok);
    if (!ok) return;
    d = '0; d.alusrc_b = 2'd3;
    case (op)
      35, 43: begin
        step("decode", d, rnd());
        d = '0; d.alusrc_a = 1; d.alusrc_b = 2'd2;
        step("mem_addr", d, rnd());
        w = '0; w.iord = 1;
        if (op == 35) begin
          w.mem_read = 1;
          mem_phase("lw_read", w, w, lm, ok);
          if (ok) begin
            d = '0; d.regwrite = 1; d.memtoreg = 2'd1; d.instr_done = 1;
            step("lw_wb", d, rnd());
          end
        end else begin
          w.mem_write = 1;
          d = w; d.instr_done = 1;
          mem_phase("sw_write", w, d, lm, ok);
        end
      end
      0: begin
        step("decode", d, rnd());
        d = '0; d.alusrc_a = 1; d.aluop = 2'd2;
        step("r_exec", d, rnd());
        d = '0; d.regwrite = 1; d.regdest = 2'd1; d.instr_done = 1;
        step("r_wb", d, rnd());
      end
      13: begin
        step("decode", d, rnd());
        d = '0; d.alusrc_a = 1; d.alusrc_b = 2'd2; d.aluop = 2'd3;
        step("ori_exec", d, rnd());
        d = '0; d.regwrite = 1; d.instr_done = 1;
        step("ori_wb", d, rnd());
      end
      4: begin
        step("decode", d, rnd());
        d = '0; d.alusrc_a = 1; d.aluop = 2'd1; d.pc_write_cond = 1;
        d.pc_source = 2'd1; d.pc_write = z; d.instr_done = 1;
        step("beq", d, rnd());
      end
      2: begin
        step("decode", d, rnd());
        d = '0; d.pc_write = 1; d.pc_source = 2'd2; d.instr_done = 1;
        step("jump", d, rnd());
      end
      34, 27: begin
        step("decode", d, rnd());
        d = '0; d.alusrc_a = 1; d.aluop = 2'd1; d.instr_done = !n;
        step("link_test", d, rnd());
        if (n) begin
          d = '0; d.regwrite = 1; d.regdest = 2'd2; d.memtoreg = 2'd2;
          d.pc_write = 1; d.pc_source = 2'd1; d.instr_done = 1;
          step("link_wb", d, rnd());
        end
      end
      19: begin
        step("decode", d, rnd());
        w = '0; w.mem_write = 1; w.iord = 1;
        mem_phase("jspal_write", w, w, lm, ok);
        if (ok) begin
          d = '0; d.pc_write = 1; d.pc_source = 2'd3; d.instr_done = 1;
          step("jspal_jump", d, rnd());
        end
      end
      default: begin
        d.illegal_op = 1; d.instr_done = 1;
        step("decode_illegal", d, rnd());
      end
    endcase
  endtask

  function automatic bit is_legal(input int op);
    return op inside {0, 35, 43, 4, 2, 13, 34, 19, 27};
  endfunction

  initial begin
    int legal_ops [9] = '{0, 35, 43, 4, 2, 13, 34, 19, 27};
    int op;
    bus.opcode    = '0;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    bus.neg       = 1'b0;

    // Reset cycle: all outputs low
    @(negedge clk);
    check_val("reset_outputs", 32'(observe()), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(0, 3, 0, 1'b0, 1'b0);    // fetch wait of 3, R-format
    run_instr(35, 0, 0, 1'b0, 1'b0);   // lw, no wait
    run_instr(4, 0, 0, 1'b1, 1'b0);    // beq taken
    run_instr(4, 0, 0, 1'b0, 1'b0);    // beq not taken
    run_instr(34, 0, 0, 1'b0, 1'b1);   // bltzal neg=1
    run_instr(34, 0, 0, 1'b0, 1'b0);   // bltzal neg=0
    run_instr(63, 0, 0, 1'b0, 1'b0);   // illegal
    run_instr(13, 1, 0, 1'b0, 1'b0);
    run_instr(2, 0, 0, 1'b0, 1'b0);
    run_instr(19, 0, 2, 1'b0, 1'b0);
    run_instr(27, 0, 0, 1'b0, 1'b1);
    run_instr(35, 2, 14, 1'b0, 1'b0);  // one short of the timeout
    run_instr(43, 0, 20, 1'b0, 1'b0);  // sw stuck: timeout
    run_instr(0, 0, 0, 1'b0, 1'b0);    // mem_err must stay set
    run_instr(43, 0, -1, 1'b0, 1'b0);  // reset mid-write
    run_instr(0, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = int'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      run_instr(op, int'($urandom_range(0, 3)),
                ($urandom_range(0, 49) == 0) ? 20 : int'($urandom_range(0, 3)),
                rnd(), rnd());
    end

    @(negedge clk);
    check_val("instr_done_count", 32'(obs_done), 32'(exp_done));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
